// File: rtl/exec_unit_if.sv
// Memory request/ack bus and CDB broadcast bundle of the execute stage.
interface exec_unit_if #(
  parameter int PREG_WIDTH = 6,
  parameter int ROB_WIDTH  = 6
);
  logic                  mem_req;
  logic                  mem_we;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_be;
  logic                  mem_ack;
  logic [31:0]           mem_rdata;
  logic                  cdb_valid;
  logic [PREG_WIDTH-1:0] cdb_preg;
  logic [31:0]           cdb_data;
  logic [ROB_WIDTH-1:0]  cdb_rob;
  logic                  cdb_regwr;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata,
    output cdb_valid, cdb_preg, cdb_data, cdb_rob, cdb_regwr
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata,
    input  cdb_valid, cdb_preg, cdb_data, cdb_rob, cdb_regwr
  );
endinterface

// File: rtl/exec_unit.sv
// Execute stage: two single-cycle ALUs, one load/store unit, round-robin CDB.
// LSU states:  IDLE | no memory op held
//              REQ  | mem_req asserted, waiting for mem_ack
//              DONE | load/store result held, waiting for CDB grant
module exec_unit #(
  parameter int RS_WIDTH   = 145,
  parameter int PREG_WIDTH = 6,
  parameter int ROB_WIDTH  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RS_WIDTH-1:0] instr_in0,
  input  logic [RS_WIDTH-1:0] instr_in1,
  input  logic [RS_WIDTH-1:0] instr_in2,
  input  logic [2:0]          instr_valid,
  output logic [2:0]          fu_free,
  output logic                issue_err,
  exec_unit_if.master         bus
);

  typedef struct packed {
    logic                  in_use;
    logic [2:0]            alu_op;
    logic [2:0]            funct3;
    logic [6:0]            c_sigs;
    logic [6:0]            opcode;
    logic [PREG_WIDTH-1:0] rd;
    logic [PREG_WIDTH-1:0] src1;
    logic [31:0]           data1;
    logic                  ready1;
    logic [PREG_WIDTH-1:0] src2;
    logic [31:0]           data2;
    logic                  ready2;
    logic [31:0]           imm;
    logic [1:0]            fu_pos;
    logic [ROB_WIDTH-1:0]  rob_num;
  } rs_entry_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} lsu_state_t;

  function automatic logic [31:0] alu_calc(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      3'b000:  alu_calc = a + b;
      3'b001:  alu_calc = a - b;
      3'b010:  alu_calc = a & b;
      3'b011:  alu_calc = a | b;
      3'b100:  alu_calc = a ^ b;
      3'b101:  alu_calc = a << b[4:0];
      3'b110:  alu_calc = a >> b[4:0];
      default: alu_calc = $unsigned($signed(a) >>> b[4:0]);
    endcase
  endfunction

  rs_entry_t             ent [3];
  logic                  unused_fields;
  logic [1:0]            alu_full;
  logic [PREG_WIDTH-1:0] alu_preg [2];
  logic [31:0]           alu_data [2];
  logic [ROB_WIDTH-1:0]  alu_rob  [2];
  logic [1:0]            alu_regwr;
  lsu_state_t            lsu_state, lsu_next;
  logic                  lsu_byte, lsu_store, lsu_regwr;
  logic [PREG_WIDTH-1:0] lsu_preg;
  logic [ROB_WIDTH-1:0]  lsu_rob;
  logic [31:0]           lsu_data;
  logic [31:0]           lsu_addr;
  logic [7:0]            ld_byte;
  logic [2:0]            busy, cand;
  logic [1:0]            rr_ptr, grant;
  logic                  grant_vld;

  assign ent[0] = rs_entry_t'(instr_in0);
  assign ent[1] = rs_entry_t'(instr_in1);
  assign ent[2] = rs_entry_t'(instr_in2);
  assign unused_fields = ^{ent[0], ent[1], ent[2]};

  assign busy    = {lsu_state != S_IDLE, alu_full};
  assign fu_free = ~busy & ~instr_valid;
  assign cand    = {lsu_state == S_DONE, alu_full};
  assign lsu_addr = ent[2].data1 + ent[2].imm;

  // Candidates are registered, so an entry accepted this edge waits one more.
  always_comb begin
    grant_vld = |cand;
    case (rr_ptr)
      2'd1:    grant = cand[1] ? 2'd1 : (cand[2] ? 2'd2 : 2'd0);
      2'd2:    grant = cand[2] ? 2'd2 : (cand[0] ? 2'd0 : 2'd1);
      default: grant = cand[0] ? 2'd0 : (cand[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_full  <= 2'b00;
      alu_regwr <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        alu_preg[k] <= '0;
        alu_data[k] <= '0;
        alu_rob[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (grant_vld && grant == 2'(k)) alu_full[k] <= 1'b0;
        if (instr_valid[k] && !alu_full[k]) begin
          alu_full[k]  <= 1'b1;
          alu_preg[k]  <= ent[k].rd;
          alu_rob[k]   <= ent[k].rob_num;
          alu_regwr[k] <= ent[k].c_sigs[3];
          alu_data[k]  <= alu_calc(ent[k].alu_op, ent[k].data1,
                                   ent[k].c_sigs[0] ? ent[k].imm : ent[k].data2);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lsu_state <= S_IDLE;
    else     lsu_state <= lsu_next;
  end

  always_comb begin
    lsu_next = lsu_state;
    case (lsu_state)
      S_IDLE:  if (instr_valid[2]) lsu_next = S_REQ;
      S_REQ:   if (bus.mem_ack) lsu_next = S_DONE;
      S_DONE:  if (grant_vld && grant == 2'd2) lsu_next = S_IDLE;
      default: lsu_next = S_IDLE;
    endcase
  end

  always_comb begin
    case (bus.mem_addr[1:0])
      2'd0:    ld_byte = bus.mem_rdata[7:0];
      2'd1:    ld_byte = bus.mem_rdata[15:8];
      2'd2:    ld_byte = bus.mem_rdata[23:16];
      default: ld_byte = bus.mem_rdata[31:24];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
      lsu_byte      <= 1'b0;
      lsu_store     <= 1'b0;
      lsu_regwr     <= 1'b0;
      lsu_preg      <= '0;
      lsu_rob       <= '0;
      lsu_data      <= '0;
    end else if (lsu_state == S_IDLE && instr_valid[2]) begin
      bus.mem_req  <= 1'b1;
      bus.mem_we   <= ent[2].c_sigs[2];
      bus.mem_addr <= lsu_addr;
      lsu_byte     <= ent[2].funct3 == 3'b000;
      lsu_store    <= ent[2].c_sigs[2];
      lsu_regwr    <= ent[2].c_sigs[3] & ~ent[2].c_sigs[2];
      lsu_preg     <= ent[2].rd;
      lsu_rob      <= ent[2].rob_num;
      if (ent[2].funct3 == 3'b000) begin
        bus.mem_be    <= 4'b0001 << lsu_addr[1:0];
        bus.mem_wdata <= {4{ent[2].data2[7:0]}};
      end else begin
        bus.mem_be    <= 4'b1111;
        bus.mem_wdata <= ent[2].data2;
      end
    end else if (lsu_state == S_REQ && bus.mem_ack) begin
      bus.mem_req <= 1'b0;
      if (lsu_store)     lsu_data <= '0;
      else if (lsu_byte) lsu_data <= {{24{ld_byte[7]}}, ld_byte};
      else               lsu_data <= bus.mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       issue_err <= 1'b0;
    else if (|(instr_valid & busy)) issue_err <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr        <= 2'd0;
      bus.cdb_valid <= 1'b0;
      bus.cdb_preg  <= '0;
      bus.cdb_data  <= '0;
      bus.cdb_rob   <= '0;
      bus.cdb_regwr <= 1'b0;
    end else begin
      bus.cdb_valid <= grant_vld;
      if (grant_vld) begin
        rr_ptr <= (grant == 2'd2) ? 2'd0 : grant + 2'd1;
        case (grant)
          2'd0, 2'd1: begin
            bus.cdb_preg  <= alu_preg[grant[0]];
            bus.cdb_data  <= alu_data[grant[0]];
            bus.cdb_rob   <= alu_rob[grant[0]];
            bus.cdb_regwr <= alu_regwr[grant[0]];
          end
          default: begin
            bus.cdb_preg  <= lsu_preg;
            bus.cdb_data  <= lsu_data;
            bus.cdb_rob   <= lsu_rob;
            bus.cdb_regwr <= lsu_regwr;
          end
        endcase
      end
    end
  end

endmodule
